// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with a combinational hit path and
// word-by-word line refill over a req/done handshake; a flush aborts cleanly.
module icache_direct #(
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        fetch_en,
   input  logic [31:0] fetch_PC,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   input  logic        flush_in,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << OFFSET_BITS;
   localparam int TAG_LSB  = OFFSET_BITS + INDEX_BITS + 2;
   localparam int TAG_BITS = 32 - TAG_LSB;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REFILL = 2'd1;
   localparam logic [1:0] S_ABORT  = 2'd2;

   localparam logic [OFFSET_BITS-1:0] CNT_LAST = '1;

   logic [1:0]             state_q, state_d;
   logic [LINES-1:0]       valid_q, valid_d;
   logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
   logic                   mem_req_q, mem_req_d;
   logic [31:0]            mem_addr_q, mem_addr_d;
   logic [INDEX_BITS-1:0]  miss_idx_q, miss_idx_d;
   logic [TAG_BITS-1:0]    miss_tag_q, miss_tag_d;

   logic [TAG_BITS-1:0]    tag_mem  [LINES];
   logic [31:0]            data_mem [LINES][WORDS];
   logic                   data_we, tag_we;

   logic [OFFSET_BITS-1:0] pc_off;
   logic [INDEX_BITS-1:0]  pc_idx;
   logic [TAG_BITS-1:0]    pc_tag;
   logic                   hit;
   logic                   unused_pc_lsb;

   assign pc_off        = fetch_PC[OFFSET_BITS+1:2];
   assign pc_idx        = fetch_PC[TAG_LSB-1:OFFSET_BITS+2];
   assign pc_tag        = fetch_PC[31:TAG_LSB];
   assign unused_pc_lsb = ^fetch_PC[1:0];

   // Hit is evaluated against the live PC so the fetcher gets data in the request cycle.
   assign hit        = fetch_en && (state_q == S_IDLE) && valid_q[pc_idx] &&
                       (tag_mem[pc_idx] == pc_tag);
   assign inst_valid = hit;
   assign inst_data  = hit ? data_mem[pc_idx][pc_off] : 32'd0;

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d    = state_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      miss_idx_d = miss_idx_q;
      miss_tag_d = miss_tag_q;
      data_we    = 1'b0;
      tag_we     = 1'b0;

      if (rdy_in) begin
         case (state_q)
            S_IDLE: begin
               if (fetch_en && !flush_in && !hit) begin
                  miss_idx_d      = pc_idx;
                  miss_tag_d      = pc_tag;
                  valid_d[pc_idx] = 1'b0;
                  cnt_d           = '0;
                  mem_req_d       = 1'b1;
                  mem_addr_d      = {pc_tag, pc_idx, {(OFFSET_BITS + 2){1'b0}}};
                  state_d         = S_REFILL;
               end
            end
            S_REFILL: begin
               if (flush_in) begin
                  // An outstanding controller request must still complete before we idle.
                  if (mem_done) begin
                     mem_req_d = 1'b0;
                     state_d   = S_IDLE;
                  end else begin
                     state_d = S_ABORT;
                  end
               end else if (mem_done) begin
                  data_we = 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     tag_we              = 1'b1;
                     valid_d[miss_idx_q] = 1'b1;
                     mem_req_d           = 1'b0;
                     state_d             = S_IDLE;
                  end else begin
                     cnt_d      = cnt_q + 1'b1;
                     mem_addr_d = mem_addr_q + 32'd4;
                  end
               end
            end
            S_ABORT: begin
               if (mem_done) begin
                  mem_req_d = 1'b0;
                  state_d   = S_IDLE;
               end
            end
            default: begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
      if (rst_in) begin
         state_q    <= S_IDLE;
         valid_q    <= '0;
         cnt_q      <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'd0;
         miss_idx_q <= '0;
         miss_tag_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         miss_idx_q <= miss_idx_d;
         miss_tag_q <= miss_tag_d;
      end
   end

   // NOTE: the tag/data arrays are not reset; the valid bits alone say whether their contents mean anything.
   always_ff @(posedge clk_in) begin
      if (data_we) data_mem[miss_idx_q][cnt_q] <= mem_data;
      if (tag_we)  tag_mem[miss_idx_q]         <= miss_tag_q;
   end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: stimulus pushes expected fetch words and
// refill addresses into queues, a negedge monitor pops and compares them.
module tb_icache_direct;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        fetch_en;
   logic [31:0] fetch_PC;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic        flush_in;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_data;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_addr_q [$];
   logic [31:0] exp_inst_q [$];

   logic [3:0][31:0] w0, w1, w2, w3;

   icache_direct #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rdy_in     (rdy_in),
      .fetch_en   (fetch_en),
      .fetch_PC   (fetch_PC),
      .inst_valid (inst_valid),
      .inst_data  (inst_data),
      .flush_in   (flush_in),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_done   (mem_done),
      .mem_data   (mem_data)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every completed handshake and every hit is matched against the queues.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (mem_done && rdy_in && mem_req) begin
            if (exp_addr_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL mem_addr: unexpected handshake at 0x%08h, expected none (t=%0t)", mem_addr, $time);
            end else begin
               check("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
         end
         if (inst_valid) begin
            if (exp_inst_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL inst_hit: unexpected hit PC=0x%08h data 0x%08h, expected miss (t=%0t)", fetch_PC, inst_data, $time);
            end else begin
               check("inst_data", inst_data, exp_inst_q.pop_front());
            end
         end else begin
            check("inst_data_on_miss", inst_data, 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Present a missing PC; the request must appear right after the next edge.
   task automatic start_miss(input logic [31:0] pc, input logic [31:0] base);
      fetch_en = 1'b1;
      fetch_PC = pc;
      @(negedge clk_in);
      check("miss_no_hit", {31'd0, inst_valid}, 32'd0);
      tick();
      check("miss_req_up", {31'd0, mem_req}, 32'd1);
      check("miss_req_addr", mem_addr, base);
   endtask

   // One idle latency cycle, then a single-cycle done pulse carrying the word.
   task automatic serve(input logic [31:0] addr, input logic [31:0] word);
      @(negedge clk_in);
      check("req_hold", {31'd0, mem_req}, 32'd1);
      check("addr_hold", mem_addr, addr);
      tick();
      exp_addr_q.push_back(addr);
      mem_done = 1'b1;
      mem_data = word;
      tick();
      mem_done = 1'b0;
      mem_data = 32'd0;
   endtask

   task automatic refill(input logic [31:0] base, input logic [3:0][31:0] w);
      for (int i = 0; i < 4; i++) serve(base + 32'(i * 4), w[i]);
      check("refill_req_drop", {31'd0, mem_req}, 32'd0);
   endtask

   initial begin
      w0 = {32'h00300193, 32'h00200113, 32'h00100093, 32'h00000013};
      w1 = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
      w2 = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
      w3 = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};

      rst_in   = 1'b1;
      rdy_in   = 1'b1;
      fetch_en = 1'b1;
      fetch_PC = 32'h0;
      flush_in = 1'b0;
      mem_done = 1'b0;
      mem_data = 32'h0;

      // Reset state
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      @(posedge clk_in);
      #1 rst_in = 1'b0;

      // Cold miss at 0x0, then same-line hits
      start_miss(32'h0, 32'h0);
      refill(32'h0, w0);
      exp_inst_q.push_back(w0[0]);
      tick();
      for (int i = 1; i < 4; i++) begin
         fetch_PC = 32'(i * 4);
         exp_inst_q.push_back(w0[i]);
         tick();
         check("hit_no_req", {31'd0, mem_req}, 32'd0);
      end

      // Conflict miss on index 0 with a different tag
      start_miss(32'h100, 32'h100);
      refill(32'h100, w1);
      flush_in = 1'b1;
      exp_inst_q.push_back(w1[0]);
      tick();
      check("flush_idle_hit_no_req", {31'd0, mem_req}, 32'd0);
      fetch_PC = 32'h0;
      @(negedge clk_in);
      check("evicted_line_miss", {31'd0, inst_valid}, 32'd0);
      tick();
      check("flush_idle_no_miss", {31'd0, mem_req}, 32'd0);
      flush_in = 1'b0;
      fetch_PC = 32'h104;
      exp_inst_q.push_back(w1[1]);
      tick();

      // Flush one cycle after the first done: ABORT holds the request
      start_miss(32'h40, 32'h40);
      serve(32'h40, w2[0]);
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      check("abort_req_held", {31'd0, mem_req}, 32'd1);
      check("abort_addr_held", mem_addr, 32'h44);
      tick();
      check("abort_req_still", {31'd0, mem_req}, 32'd1);
      exp_addr_q.push_back(32'h44);
      mem_done = 1'b1;
      mem_data = w2[1];
      tick();
      mem_done = 1'b0;
      check("abort_req_drop", {31'd0, mem_req}, 32'd0);

      // 0x40 misses again; flush coincident with the first done
      start_miss(32'h40, 32'h40);
      @(negedge clk_in);
      tick();
      exp_addr_q.push_back(32'h40);
      mem_done = 1'b1;
      mem_data = w2[0];
      flush_in = 1'b1;
      fetch_en = 1'b0;
      tick();
      mem_done = 1'b0;
      flush_in = 1'b0;
      check("flush_done_req_drop", {31'd0, mem_req}, 32'd0);
      tick();
      check("flush_done_no_new_req", {31'd0, mem_req}, 32'd0);

      // rdy_in low for 3 cycles mid-refill with a stray done pulse
      start_miss(32'h40, 32'h40);
      serve(32'h40, w2[0]);
      rdy_in = 1'b0;
      tick();
      mem_done = 1'b1;
      mem_data = 32'hDEADBEEF;
      tick();
      mem_done = 1'b0;
      mem_data = 32'h0;
      tick();
      rdy_in = 1'b1;
      check("stall_req_held", {31'd0, mem_req}, 32'd1);
      check("stall_addr_held", mem_addr, 32'h44);
      serve(32'h44, w2[1]);
      serve(32'h48, w2[2]);
      serve(32'h4C, w2[3]);
      check("stall_refill_done", {31'd0, mem_req}, 32'd0);
      exp_inst_q.push_back(w2[0]);
      tick();
      fetch_PC = 32'h44;
      exp_inst_q.push_back(w2[1]);
      tick();
      fetch_PC = 32'h4C;
      exp_inst_q.push_back(w2[3]);
      tick();
      fetch_PC = 32'h108;
      exp_inst_q.push_back(w1[2]);
      tick();

      // Async reset mid-refill takes effect before the next edge
      start_miss(32'h80, 32'h80);
      serve(32'h80, w3[0]);
      #2 rst_in = 1'b1;
      #1;
      check("arst_mem_req", {31'd0, mem_req}, 32'd0);
      check("arst_mem_addr", mem_addr, 32'd0);
      check("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
      @(posedge clk_in);
      #1 rst_in = 1'b0;
      #1;
      check("arst_partial_line_invalid", {31'd0, inst_valid}, 32'd0);
      fetch_PC = 32'h40;
      #1;
      check("arst_line_40_invalid", {31'd0, inst_valid}, 32'd0);
      fetch_en = 1'b0;
      tick();
      tick();
      check("arst_idle_no_req", {31'd0, mem_req}, 32'd0);

      check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
      check("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
